// File: rtl/gate_window_ctrl.sv
// Measurement-window sequencer: clears the edge counter, gates it for win_len prescaler ticks,
// then latches the count onto a valid/ready result port. Optional wrap tracker: GATE_WINDOW_OVF_EN.
module gate_window_ctrl #(
    parameter int unsigned CNT_W = 4,
    parameter int unsigned WIN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_in,
    input  logic             start,
    input  logic             continuous,
    input  logic [WIN_W-1:0] win_len,
    input  logic [CNT_W-1:0] cnt_val,
    output logic             cnt_clr,
    output logic             cnt_en,
    output logic             busy,
    output logic [CNT_W-1:0] result,
    output logic             result_ovf,
    output logic             result_valid,
    input  logic             result_ready
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        WAIT_TICK,
        COUNT,
        LATCH,
        HOLD
    } state_t;

    state_t           state;
    logic [WIN_W-1:0] win_cnt;
    logic [WIN_W-1:0] win_load;

    // A zero-length window behaves like a one-tick window.
    assign win_load = (win_len == '0) ? WIN_W'(1) : win_len;

    // Sequencer with all strobes registered alongside the state transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            win_cnt      <= '0;
            cnt_clr      <= 1'b0;
            cnt_en       <= 1'b0;
            busy         <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
        end else begin
            cnt_clr <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= CLEAR;
                        cnt_clr <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                CLEAR: begin
                    state <= WAIT_TICK;
                end
                WAIT_TICK: begin
                    if (tick_in) begin
                        win_cnt <= win_load;
                        state   <= COUNT;
                        cnt_en  <= 1'b1;
                    end
                end
                COUNT: begin
                    if (tick_in) begin
                        win_cnt <= win_cnt - WIN_W'(1);
                        if (win_cnt == WIN_W'(1)) begin
                            state  <= LATCH;
                            cnt_en <= 1'b0;
                        end
                    end
                end
                LATCH: begin
                    // Counter's registered value now includes the final enabled cycle.
                    result       <= cnt_val;
                    result_valid <= 1'b1;
                    state        <= HOLD;
                end
                HOLD: begin
                    if (result_ready) begin
                        result_valid <= 1'b0;
                        if (continuous) begin
                            state   <= CLEAR;
                            cnt_clr <= 1'b1;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state        <= IDLE;
                    cnt_en       <= 1'b0;
                    busy         <= 1'b0;
                    result_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef GATE_WINDOW_OVF_EN
    logic [CNT_W-1:0] prev_val;
    logic             ovf_flag;
    logic             wrap;

    assign wrap = (cnt_val < prev_val);

    // Sticky wrap detector: a drop in the counter value during the window means it rolled over.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_val   <= '0;
            ovf_flag   <= 1'b0;
            result_ovf <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    prev_val <= '0;
                    ovf_flag <= 1'b0;
                end
                COUNT: begin
                    prev_val <= cnt_val;
                    if (wrap) begin
                        ovf_flag <= 1'b1;
                    end
                end
                LATCH: begin
                    prev_val   <= cnt_val;
                    result_ovf <= ovf_flag | wrap;
                end
                default: ;
            endcase
        end
    end
`else
    assign result_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_gate_window_ctrl.sv
// Self-checking bench for gate_window_ctrl: edge-counter model, free-running tick, result scoreboard.
module tb_gate_window_ctrl;

    localparam int unsigned CNT_W = 4;
    localparam int unsigned WIN_W = 8;
`ifdef GATE_WINDOW_OVF_EN
    localparam logic OVF_ON = 1'b1;
`else
    localparam logic OVF_ON = 1'b0;
`endif

    typedef struct packed {
        logic [CNT_W-1:0] res;
        logic             ovf;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             tick_in = 1'b0;
    logic             start = 1'b0;
    logic             continuous = 1'b0;
    logic             result_ready = 1'b0;
    logic [WIN_W-1:0] win_len = '0;
    logic [CNT_W-1:0] cnt_val;
    logic             cnt_clr;
    logic             cnt_en;
    logic             busy;
    logic [CNT_W-1:0] result;
    logic             result_ovf;
    logic             result_valid;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    int   cyc = 0;
    int   clr_total = 0;
    int   en_total = 0;
    int   last_tick_cyc = 0;
    int   rise_cyc = 0;
    logic prev_valid = 1'b0;

    int   ev_sent = 0;
    int   ev_target = 0;
    logic ev = 1'b0;
    logic [CNT_W-1:0] cnt_model = '0;

    gate_window_ctrl #(.CNT_W(CNT_W), .WIN_W(WIN_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .tick_in      (tick_in),
        .start        (start),
        .continuous   (continuous),
        .win_len      (win_len),
        .cnt_val      (cnt_val),
        .cnt_clr      (cnt_clr),
        .cnt_en       (cnt_en),
        .busy         (busy),
        .result       (result),
        .result_ovf   (result_ovf),
        .result_valid (result_valid),
        .result_ready (result_ready)
    );

    always #5 clk = ~clk;

    // Edge counter with one register of latency, as the DUT expects.
    always @(posedge clk) begin
        if (cnt_clr) cnt_model <= '0;
        else if (cnt_en && ev) cnt_model <= cnt_model + CNT_W'(1);
    end
    assign cnt_val = cnt_model;

    // Prescaler tick every 4 clocks.
    initial begin
        int phase;
        phase = 0;
        forever begin
            @(posedge clk);
            #1;
            tick_in = (phase == 0);
            phase = (phase + 1) % 4;
        end
    end

    // Edge events fired only while the gate is open, until the requested number is reached.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            ev = cnt_en && (ev_sent < ev_target);
            if (ev) ev_sent++;
        end
    end

    // Passive monitor of strobe activity and timing.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (cnt_clr) clr_total++;
            if (cnt_en) en_total++;
            if (tick_in && cnt_en) last_tick_cyc = cyc;
            if (result_valid && !prev_valid) rise_cyc = cyc;
            prev_valid = result_valid;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion before 50000 cycles");
        $fatal(1, "watchdog expired");
    end

    task automatic pulse_start();
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(negedge clk);
    endtask

    task automatic handshake();
        @(posedge clk); #1; result_ready = 1'b1;
        @(posedge clk); #1; result_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_valid(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (result_valid) begin
                ok = 1'b1;
                break;
            end
        end
        #1;
    endtask

    task automatic wait_en(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (cnt_en) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({cnt_clr, cnt_en, busy, result_valid, result_ovf} !== 5'b0) begin
            errors++;
            $display("FAIL reset_strobes: clr/en/busy/valid/ovf=%b required 00000",
                     {cnt_clr, cnt_en, busy, result_valid, result_ovf});
        end
        checks++;
        if (result !== '0) begin
            errors++;
            $display("FAIL reset_result: got %0d required 0", result);
        end
        @(posedge clk); #1; rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_shot();
        bit ok;
        int clr0, en0;
        exp_t e;
        win_len = 8'd3;
        continuous = 1'b0;
        clr0 = clr_total;
        en0 = en_total;
        ev_target = ev_sent + 5;
        e = '{res: 4'd5, ovf: 1'b0};
        sb.push_back(e);
        pulse_start();
        checks++;
        if (cnt_clr !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL ss_start_clr: cnt_clr=%b busy=%b required 1 1", cnt_clr, busy);
        end
        wait_valid(200, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL ss_timeout: result_valid=0 after 200 cycles, required 1");
        end
        checks++;
        if (clr_total - clr0 !== 1) begin
            errors++;
            $display("FAIL ss_clr_pulses: got %0d required 1", clr_total - clr0);
        end
        checks++;
        if (en_total - en0 !== 12) begin
            errors++;
            $display("FAIL ss_en_cycles: got %0d required 12", en_total - en0);
        end
        checks++;
        if (rise_cyc - last_tick_cyc !== 2) begin
            errors++;
            $display("FAIL ss_latency: valid %0d cycles after final tick, required 2", rise_cyc - last_tick_cyc);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            if (result !== e.res || result_ovf !== e.ovf) begin
                errors++;
                $display("FAIL ss_result: got %0d/%b required %0d/%b", result, result_ovf, e.res, e.ovf);
            end
        end
        handshake();
        checks++;
        if (result_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ss_to_idle: valid=%b busy=%b required 0 0", result_valid, busy);
        end
        checks++;
        if (result !== 4'd5) begin
            errors++;
            $display("FAIL ss_result_hold: got %0d required 5", result);
        end
    endtask

    task automatic test_win_zero();
        bit ok;
        int en0;
        exp_t e;
        win_len = 8'd0;
        continuous = 1'b0;
        en0 = en_total;
        ev_target = ev_sent + 2;
        e = '{res: 4'd2, ovf: 1'b0};
        sb.push_back(e);
        pulse_start();
        wait_valid(200, ok);
        checks++;
        if (!ok || en_total - en0 !== 4) begin
            errors++;
            $display("FAIL wz_en_cycles: valid=%b en cycles %0d required 1 and 4", ok, en_total - en0);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            if (result !== e.res) begin
                errors++;
                $display("FAIL wz_result: got %0d required %0d", result, e.res);
            end
        end
        handshake();
    endtask

    task automatic test_continuous();
        bit ok;
        bit stall_bad;
        int en0, clr0;
        logic [CNT_W-1:0] r0;
        exp_t e;
        win_len = 8'd2;
        continuous = 1'b1;
        en0 = en_total;
        ev_target = ev_sent + 3;
        e = '{res: 4'd3, ovf: 1'b0};
        sb.push_back(e);
        pulse_start();
        wait_valid(200, ok);
        checks++;
        if (!ok || en_total - en0 !== 8) begin
            errors++;
            $display("FAIL ct_en_cycles1: valid=%b en cycles %0d required 1 and 8", ok, en_total - en0);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            if (result !== e.res) begin
                errors++;
                $display("FAIL ct_result1: got %0d required %0d", result, e.res);
            end
        end
        en0 = en_total;
        r0 = result;
        stall_bad = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (result_valid !== 1'b1 || result !== r0) stall_bad = 1'b1;
        end
        #1;
        checks++;
        if (stall_bad || en_total != en0) begin
            errors++;
            $display("FAIL ct_stall: unstable=%b en cycles %0d required 0 and 0", stall_bad, en_total - en0);
        end
        ev_target = ev_sent + 4;
        e = '{res: 4'd4, ovf: 1'b0};
        sb.push_back(e);
        clr0 = clr_total;
        en0 = en_total;
        handshake();
        checks++;
        if (cnt_clr !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL ct_rearm_clr: cnt_clr=%b busy=%b required 1 1", cnt_clr, busy);
        end
        wait_valid(200, ok);
        checks++;
        if (!ok || en_total - en0 !== 8 || clr_total - clr0 !== 1) begin
            errors++;
            $display("FAIL ct_window2: valid=%b en %0d clr %0d required 1, 8, 1",
                     ok, en_total - en0, clr_total - clr0);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            if (result !== e.res) begin
                errors++;
                $display("FAIL ct_result2: got %0d required %0d", result, e.res);
            end
        end
        continuous = 1'b0;
        handshake();
        checks++;
        if (busy !== 1'b0 || result_valid !== 1'b0) begin
            errors++;
            $display("FAIL ct_stop: busy=%b valid=%b required 0 0", busy, result_valid);
        end
    endtask

    task automatic test_ignored();
        bit ok;
        int en0, clr0;
        exp_t e;
        continuous = 1'b0;
        clr0 = clr_total;
        handshake();
        checks++;
        if (busy !== 1'b0 || result_valid !== 1'b0 || clr_total != clr0) begin
            errors++;
            $display("FAIL ig_stray_ready: busy=%b valid=%b clr %0d required 0 0 0",
                     busy, result_valid, clr_total - clr0);
        end
        win_len = 8'd3;
        en0 = en_total;
        clr0 = clr_total;
        ev_target = ev_sent + 1;
        e = '{res: 4'd1, ovf: 1'b0};
        sb.push_back(e);
        pulse_start();
        wait_en(100, ok);
        @(posedge clk); #1; start = 1'b1; win_len = 8'd7;
        @(posedge clk); #1; start = 1'b0;
        wait_valid(200, ok);
        checks++;
        if (!ok || en_total - en0 !== 12) begin
            errors++;
            $display("FAIL ig_window: valid=%b en cycles %0d required 1 and 12", ok, en_total - en0);
        end
        pulse_start();
        #1;
        checks++;
        if (cnt_clr !== 1'b0 || result_valid !== 1'b1 || clr_total - clr0 !== 1) begin
            errors++;
            $display("FAIL ig_start_hold: clr=%b valid=%b clr pulses %0d required 0 1 1",
                     cnt_clr, result_valid, clr_total - clr0);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            if (result !== e.res) begin
                errors++;
                $display("FAIL ig_result: got %0d required %0d", result, e.res);
            end
        end
        handshake();
        win_len = 8'd3;
    endtask

    task automatic test_overflow();
        bit ok;
        exp_t e;
        win_len = 8'd5;
        continuous = 1'b0;
        ev_target = ev_sent + 18;
        e = '{res: 4'd2, ovf: OVF_ON};
        sb.push_back(e);
        pulse_start();
        wait_valid(300, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL ov_timeout: result_valid=0 after 300 cycles, required 1");
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            if (result !== e.res || result_ovf !== e.ovf) begin
                errors++;
                $display("FAIL ov_result: got %0d/%b required %0d/%b", result, result_ovf, e.res, e.ovf);
            end
        end
        handshake();
    endtask

    task automatic test_reset_midcount();
        bit ok;
        int clr0;
        win_len = 8'd3;
        ev_target = ev_sent;
        pulse_start();
        wait_en(100, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rm_no_count: cnt_en=0 after 100 cycles, required 1");
        end
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if ({cnt_clr, cnt_en, busy, result_valid, result_ovf} !== 5'b0 || result !== '0) begin
            errors++;
            $display("FAIL rm_outputs: clr/en/busy/valid/ovf=%b result=%0d required 00000 0",
                     {cnt_clr, cnt_en, busy, result_valid, result_ovf}, result);
        end
        @(posedge clk); #1; rst = 1'b0;
        #1;
        clr0 = clr_total;
        repeat (10) @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || clr_total != clr0) begin
            errors++;
            $display("FAIL rm_stays_idle: busy=%b clr pulses %0d required 0 0", busy, clr_total - clr0);
        end
    endtask

    initial begin
        test_reset();
        test_single_shot();
        test_win_zero();
        test_continuous();
        test_ignored();
        test_overflow();
        test_reset_midcount();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d results outstanding, required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gate_window_ctrl.md
# gate_window_ctrl

- Measurement-window sequencer for the edge-event counter.
- Uses the prescaler's one-cycle tick to open a gate of programmable length.
- Clears and enables the counter for exactly that many ticks, then latches the final count.
- Presents the count on a valid/ready result port, in single-shot or back-to-back continuous mode.

## Interface
Parameters:
- CNT_W, 4, width of the edge-counter value being sampled
- WIN_W, 8, width of the window-length register (window in prescaler ticks)

Ports:
- clk  in  1  system clock, the only clock; all logic on its rising edge
- rst  in  1  synchronous, active-high reset
- tick_in  in  1  prescaler tick, one-clk-wide pulse
- start  in  1  single-cycle request to begin a measurement
- continuous  in  1  1 = re-arm automatically after each result is accepted
- win_len  in  WIN_W  window length in ticks; 0 is treated as 1
- cnt_val  in  CNT_W  current value of the edge counter (registered in the counter)
- cnt_clr  out  1  clear strobe to the edge counter
- cnt_en  out  1  count enable to the edge counter
- busy  out  1  high in every state except IDLE
- result  out  CNT_W  latched count
- result_ovf  out  1  counter wrapped during the window (see Configuration)
- result_valid  out  1  result available
- result_ready  in  1  consumer accepts the result

## Operation
- Moore FSM; all outputs are registered or decoded from registered state.
- States: IDLE, CLEAR, WAIT_TICK, COUNT, LATCH, HOLD.
- IDLE:
  - All strobes 0.
  - start=1 → CLEAR.
  - start in any other state is ignored.
- CLEAR:
  - cnt_clr=1 for exactly one cycle.
  - Clears the overflow tracker.
  - → WAIT_TICK.
- WAIT_TICK:
  - Waits for tick_in so the window is tick-aligned.
  - On tick_in: load win_cnt ← (win_len==0 ? 1 : win_len), → COUNT.
  - This aligning tick is not counted.
- COUNT:
  - cnt_en=1.
  - Each tick_in decrements win_cnt.
  - tick_in with win_cnt==1 → LATCH; cnt_en is low from the next cycle.
- LATCH:
  - cnt_en=0 for one cycle, absorbing the counter's register latency.
  - At the end of LATCH: result ← cnt_val, result_ovf ← overflow tracker.
  - → HOLD.
- HOLD:
  - result_valid=1; result and result_ovf are stable.
  - On result_valid & result_ready: → CLEAR if continuous=1 (sampled in that same cycle), else → IDLE.
- win_len is sampled only on entry to COUNT; changes during a window have no effect.
- result holds its last value after the handshake until the next LATCH.

## Timing
- Reset values (cycle after rst=1): state IDLE, cnt_clr=0, cnt_en=0, busy=0, result=0, result_ovf=0, result_valid=0, win_cnt=0.
- rst mid-operation aborts immediately. Any pending result is discarded. No cnt_clr is issued.
- start sampled at edge k → cnt_clr=1 and busy=1 during cycle k+1.
- Window length in cycles: cnt_en is high from the cycle after the aligning tick through the cycle of the Nth subsequent tick, inclusive.
- Final tick at edge t:
  - cnt_en=0 from cycle t+1.
  - LATCH in cycle t+1, HOLD/result_valid=1 from cycle t+2.
- Handshake at edge h:
  - continuous=0: result_valid=0 and busy=0 in cycle h+1.
  - continuous=1: cnt_clr=1 in cycle h+1.
- tick_in arriving in the same cycle as start is ignored; it is not treated as the aligning tick.
- result_ready while result_valid=0 is ignored.

## Configuration
- Macro GATE_WINDOW_OVF_EN.
- Defined:
  - A CNT_W-bit previous-value register samples cnt_val each COUNT/LATCH cycle.
  - Sticky ovf sets when cnt_val < previous value (wrap detected).
  - The flag is copied to result_ovf at LATCH and cleared in CLEAR.
- Undefined: no tracker logic; result_ovf is constant 0.

## Test plan
- Reset: drive rst=1 mid-COUNT with cnt_en=1 → next cycle state IDLE, all outputs 0, busy=0.
- Single shot:
  - Setup: win_len=3, continuous=0, tick every 4 clk, counter model incrementing on 5 events inside the window.
  - Required: start → one cnt_clr pulse; cnt_en high for exactly 3 tick periods; result=5, result_valid=1 two cycles after the final tick; result_ready → IDLE.
- win_len=0 → window lasts exactly 1 tick period (identical to win_len=1).
- Continuous with backpressure:
  - Setup: continuous=1, result_ready held 0 for 20 cycles.
  - Required: result_valid stays high and result stable; no cnt_en during the stall; after ready, cnt_clr fires in the next cycle and a new window starts on the following tick.
- Ignored start and stray ready:
  - start pulsed during COUNT and HOLD → no re-clear, window length unchanged.
  - result_ready with result_valid=0 → no effect.
- Overflow (GATE_WINDOW_OVF_EN defined, CNT_W=4): 18 events in the window → result=2, result_ovf=1. Without the macro, the same stimulus gives result=2, result_ovf=0.
